lab6_q2_a_m_seq: RTL and testbench



---
 rtl/lab6_q2_a_m_seq.sv | 69 ++++++
 tb/tb_lab6_q2_a_m_seq.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/lab6_q2_a_m_seq.sv
// Start-triggered 5-bit parallel-to-serial sequencer, LSB first, with a busy flag.
// Define LAB6_Q2_PARITY_EN to append an even-parity bit as a sixth serial bit.
module lab6_q2_a_m_seq (
    input  logic       clk,
    input  logic       reset,
    input  logic       baslat,
    input  logic [4:0] D,
    output logic       y,
    output logic       mesgul
);

    localparam int DATA_W = 5;
`ifdef LAB6_Q2_PARITY_EN
    localparam int FRAME_W = DATA_W + 1;
`else
    localparam int FRAME_W = DATA_W;
`endif

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] SHIFT = 1'b1;

    localparam logic [2:0] LAST_BIT = 3'(FRAME_W - 1);

    logic [0:0]         state;
    logic [FRAME_W-1:0] sreg;
    logic [2:0]         cnt;

    // Frame image as it sits in the shift register: bit 0 leaves first.
    function automatic logic [FRAME_W-1:0] load_frame(input logic [DATA_W-1:0] d);
`ifdef LAB6_Q2_PARITY_EN
        return {^d, d};
`else
        return d;
`endif
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            sreg  <= '0;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (baslat) begin
                        sreg  <= load_frame(D);
                        cnt   <= '0;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    sreg <= sreg >> 1;
                    cnt  <= cnt + 3'd1;
                    // The edge after the last bit has been shown ends the frame.
                    if (cnt == LAST_BIT) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign mesgul = (state == SHIFT);
    assign y      = (state == SHIFT) && sreg[0];

endmodule

// File: tb/tb_lab6_q2_a_m_seq.sv
// Bench for lab6_q2_a_m_seq: vector table, directed multi-cycle sequences and
// randomized traffic checked against a bit-queue reference model.
module tb_lab6_q2_a_m_seq;

`ifdef LAB6_Q2_PARITY_EN
    localparam int N = 6;
`else
    localparam int N = 5;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       baslat = 1'b0;
    logic [4:0] D = 5'b00000;
    logic       y;
    logic       mesgul;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: the bits still to be shown on y; busy whenever non-empty.
    bit mq[$];

    typedef struct {
        logic       r;
        logic       b;
        logic [4:0] d;
        logic       ey;
        logic       em;
    } vec_t;

    vec_t tbl[$];

    lab6_q2_a_m_seq dut (
        .clk    (clk),
        .reset  (reset),
        .baslat (baslat),
        .D      (D),
        .y      (y),
        .mesgul (mesgul)
    );

    always #5 clk = ~clk;

    function automatic void model_edge(input logic r, input logic b, input logic [4:0] d);
        if (r) begin
            mq.delete();
        end else if (mq.size() == 0) begin
            if (b) begin
                for (int i = 0; i < 5; i++) mq.push_back(d[i]);
`ifdef LAB6_Q2_PARITY_EN
                mq.push_back(^d);
`endif
            end
        end else begin
            void'(mq.pop_front());
        end
    endfunction

    function automatic logic model_y();
        return (mq.size() > 0) ? mq[0] : 1'b0;
    endfunction

    function automatic logic model_busy();
        return mq.size() > 0;
    endfunction

    task automatic check(input string name, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    // One clock: drive inputs mid-low phase, let the edge happen, sample 1 time unit later.
    task automatic cycle(input logic r, input logic b, input logic [4:0] d);
        @(negedge clk);
        reset  = r;
        baslat = b;
        D      = d;
        @(posedge clk);
        model_edge(r, b, d);
        #1;
        check("model_y", y, model_y());
        check("model_mesgul", mesgul, model_busy());
    endtask

    function automatic void add(input logic r, input logic b, input logic [4:0] d,
                                input logic ey, input logic em);
        vec_t v;
        v.r = r; v.b = b; v.d = d; v.ey = ey; v.em = em;
        tbl.push_back(v);
    endfunction

    initial begin
        logic [4:0] dd;
        logic       rr;
        logic       bb;

        // Basic frame 01101 -> 1,0,1,1,0 (+ parity 1)
        add(1, 0, 5'b00000, 0, 0);
        add(0, 1, 5'b01101, 1, 1);
        add(0, 0, 5'b00000, 0, 1);
        add(0, 0, 5'b00000, 1, 1);
        add(0, 0, 5'b00000, 1, 1);
        add(0, 0, 5'b00000, 0, 1);
`ifdef LAB6_Q2_PARITY_EN
        add(0, 0, 5'b00000, 1, 1);
`endif
        add(0, 0, 5'b00000, 0, 0);
        add(0, 0, 5'b00000, 0, 0);
        // Reset has priority over a simultaneous start
        add(1, 1, 5'b11111, 0, 0);
        add(0, 0, 5'b11111, 0, 0);
        // Frame 10011 -> 1,1,0,0,1; start pulse with D=0 during third bit is ignored
        add(0, 1, 5'b10011, 1, 1);
        add(0, 0, 5'b01100, 1, 1);
        add(0, 1, 5'b00000, 0, 1);
        add(0, 1, 5'b00000, 0, 1);
        add(0, 0, 5'b00000, 1, 1);
`ifdef LAB6_Q2_PARITY_EN
        add(0, 0, 5'b00000, 1, 1);
`endif
        add(0, 0, 5'b00000, 0, 0);
        add(0, 0, 5'b00000, 0, 0);
        add(0, 0, 5'b00000, 0, 0);

        foreach (tbl[i]) begin
            cycle(tbl[i].r, tbl[i].b, tbl[i].d);
            check("tbl_y", y, tbl[i].ey);
            check("tbl_mesgul", mesgul, tbl[i].em);
        end

        // Held start with D=11111: N busy cycles of 1s, then one idle cycle, repeating.
        for (int j = 0; j < 3 * (N + 1); j++) begin
            cycle(0, 1, 5'b11111);
            check("held_mesgul", mesgul, (j % (N + 1)) != N);
            check("held_y", y, (j % (N + 1)) != N);
        end
        cycle(1, 0, 5'b00000);

        // Reset during the second bit of 10101 aborts the frame at once.
        cycle(0, 1, 5'b10101);
        check("abort_bit0", y, 1'b1);
        cycle(0, 0, 5'b10101);
        check("abort_bit1", y, 1'b0);
        cycle(1, 0, 5'b10101);
        check("abort_y", y, 1'b0);
        check("abort_mesgul", mesgul, 1'b0);
        cycle(0, 0, 5'b10101);
        check("abort_idle", mesgul, 1'b0);

        // A new frame after the abort is complete and correct.
        dd = 5'b10101;
        cycle(0, 1, dd);
        for (int i = 0; i < N; i++) begin
            if (i > 0) cycle(0, 0, ~dd);
            check("restart_y", y, (i < 5) ? dd[i] : ^dd);
            check("restart_mesgul", mesgul, 1'b1);
        end
        cycle(0, 0, 5'b00000);
        check("restart_end", mesgul, 1'b0);

        // Randomized traffic against the model.
        for (int j = 0; j < 400; j++) begin
            rr = ($urandom_range(0, 39) == 0);
            bb = ($urandom_range(0, 2) != 0);
            dd = 5'($urandom);
            cycle(rr, bb, dd);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
